// File: rtl/cs_stream_checker_if.sv
// Bundle between the CS stream checker, the CS core, the pattern/golden memories and status.
// First-mismatch capture signals exist only when CS_CHK_FIRST_ERR_EN is defined.
interface cs_stream_checker_if #(
   parameter int AW   = 15,
   parameter int ERRW = 16
);
   logic            start;
   logic            cs_reset;
   logic [7:0]      X;
   logic [9:0]      Y;
   logic [AW-1:0]   in_addr;
   logic [7:0]      in_data;
   logic [AW-1:0]   gold_addr;
   logic [9:0]      gold_data;
   logic            busy;
   logic            done;
   logic            pass;
   logic [ERRW-1:0] err_cnt;
   logic            err_valid;
   logic [AW-1:0]   err_index;
`ifdef CS_CHK_FIRST_ERR_EN
   logic            first_vld;
   logic [AW-1:0]   first_idx;
   logic [9:0]      first_y;
   logic [9:0]      first_exp;
`endif

   modport master (
      input  start, Y, in_data, gold_data,
      output cs_reset, X, in_addr, gold_addr, busy, done, pass, err_cnt, err_valid, err_index
`ifdef CS_CHK_FIRST_ERR_EN
      , output first_vld, first_idx, first_y, first_exp
`endif
   );

   modport slave (
      output start, Y, in_data, gold_data,
      input  cs_reset, X, in_addr, gold_addr, busy, done, pass, err_cnt, err_valid, err_index
`ifdef CS_CHK_FIRST_ERR_EN
      , input first_vld, first_idx, first_y, first_exp
`endif
   );
endinterface

// File: rtl/cs_stream_checker.sv
// Streams stored samples into the CS core and counts mismatches of its output against golden data.
// Define CS_CHK_FIRST_ERR_EN to add capture of the first mismatch of each run.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for start after reset
// S_RST  | CS core held in reset for two cycles, sample 0 preloaded on X
// S_RUN  | one sample per clock into X, Y checked once X index >= CMP_OFS
// S_DONE | run finished, results held, start begins a new run
module cs_stream_checker #(
   parameter int N_PAT   = 2000,
   parameter int CMP_OFS = 8,
   parameter int AW      = 15,
   parameter int ERRW    = 16
) (
   input  logic                clk_i,
   input  logic                reset_i,
   cs_stream_checker_if.master bus
);
   typedef enum logic [1:0] {S_IDLE, S_RST, S_RUN, S_DONE} state_t;

   localparam logic [AW-1:0] LAST = AW'(N_PAT - 1);
   localparam logic [AW-1:0] OFS  = AW'(CMP_OFS);

   state_t          state_q, state_d;
   logic [AW-1:0]   ptr_q, ptr_d;
   logic [AW-1:0]   xidx_q, xidx_d;
   logic [7:0]      x_q, x_d;
   logic            rst_cnt_q, rst_cnt_d;
   logic [ERRW-1:0] err_cnt_q, err_cnt_d;
   logic            err_valid_q, err_valid_d;
   logic [AW-1:0]   err_index_q, err_index_d;

   logic            run_start;
   logic            last_idx;
   logic            cmp_en;
   logic            mismatch;
   logic [AW-1:0]   gold_idx;

   assign run_start = bus.start && (state_q == S_IDLE || state_q == S_DONE);
   assign last_idx  = (xidx_q == LAST);
   assign cmp_en    = (state_q == S_RUN) && (xidx_q >= OFS);
   assign gold_idx  = (xidx_q >= OFS) ? (xidx_q - OFS) : '0;

   // Flag is cleared only on a known match, so an unknown bit on Y reads as a mismatch.
   always_comb begin
      mismatch = cmp_en;
      if ((bus.Y ^ bus.gold_data) == 10'd0) mismatch = 1'b0;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: if (bus.start) state_d = S_RST;
         S_RST:          if (rst_cnt_q == 1'b0) state_d = S_RUN;
         S_RUN:          if (last_idx) state_d = S_DONE;
         default:        state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.cs_reset = 1'b0;
      bus.busy     = 1'b0;
      bus.done     = 1'b0;
      bus.pass     = 1'b0;
      case (state_q)
         S_RST: begin
            bus.cs_reset = 1'b1;
            bus.busy     = 1'b1;
         end
         S_RUN:  bus.busy = 1'b1;
         S_DONE: begin
            bus.done = 1'b1;
            bus.pass = (err_cnt_q == '0);
         end
         default: ;
      endcase
   end

   always_comb begin
      ptr_d       = ptr_q;
      xidx_d      = xidx_q;
      x_d         = x_q;
      rst_cnt_d   = rst_cnt_q;
      err_cnt_d   = err_cnt_q;
      err_index_d = err_index_q;
      err_valid_d = 1'b0;
      if (run_start) begin
         ptr_d       = '0;
         xidx_d      = '0;
         rst_cnt_d   = 1'b1;
         err_cnt_d   = '0;
         err_index_d = '0;
      end
      case (state_q)
         S_RST: begin
            x_d    = bus.in_data;
            xidx_d = '0;
            if (rst_cnt_q != 1'b0) rst_cnt_d = 1'b0;
            else                   ptr_d     = AW'(1);
         end
         S_RUN: begin
            // X freezes on the last sample; the run ends on this edge anyway.
            if (!last_idx) begin
               x_d    = bus.in_data;
               xidx_d = ptr_q;
            end
            if (ptr_q != LAST) ptr_d = ptr_q + 1'b1;
            if (mismatch) begin
               err_valid_d = 1'b1;
               err_index_d = gold_idx;
               if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         ptr_q       <= '0;
         xidx_q      <= '0;
         x_q         <= '0;
         rst_cnt_q   <= 1'b0;
         err_cnt_q   <= '0;
         err_valid_q <= 1'b0;
         err_index_q <= '0;
      end else begin
         ptr_q       <= ptr_d;
         xidx_q      <= xidx_d;
         x_q         <= x_d;
         rst_cnt_q   <= rst_cnt_d;
         err_cnt_q   <= err_cnt_d;
         err_valid_q <= err_valid_d;
         err_index_q <= err_index_d;
      end
   end

   assign bus.X         = x_q;
   assign bus.in_addr   = ptr_q;
   assign bus.gold_addr = gold_idx;
   assign bus.err_cnt   = err_cnt_q;
   assign bus.err_valid = err_valid_q;
   assign bus.err_index = err_index_q;

`ifdef CS_CHK_FIRST_ERR_EN
   logic            first_vld_q, first_vld_d;
   logic [AW-1:0]   first_idx_q, first_idx_d;
   logic [9:0]      first_y_q, first_y_d;
   logic [9:0]      first_exp_q, first_exp_d;

   always_comb begin
      first_vld_d = first_vld_q;
      first_idx_d = first_idx_q;
      first_y_d   = first_y_q;
      first_exp_d = first_exp_q;
      if (run_start) begin
         first_vld_d = 1'b0;
         first_idx_d = '0;
         first_y_d   = '0;
         first_exp_d = '0;
      end else if (mismatch && !first_vld_q) begin
         first_vld_d = 1'b1;
         first_idx_d = gold_idx;
         first_y_d   = bus.Y;
         first_exp_d = bus.gold_data;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         first_vld_q <= 1'b0;
         first_idx_q <= '0;
         first_y_q   <= '0;
         first_exp_q <= '0;
      end else begin
         first_vld_q <= first_vld_d;
         first_idx_q <= first_idx_d;
         first_y_q   <= first_y_d;
         first_exp_q <= first_exp_d;
      end
   end

   assign bus.first_vld = first_vld_q;
   assign bus.first_idx = first_idx_q;
   assign bus.first_y   = first_y_q;
   assign bus.first_exp = first_exp_q;
`endif
endmodule
